// File: rtl/interrupt_arbiter.sv
// Sticky edge-latched interrupt arbiter with a req/ack trap handshake to the core. Nested traps are not taken.
// Latency: a rising edge on irq_in is visible in pending one edge later and raises trap_req one edge after that.
// Backpressure: trap_req is held until trap_ack. Define INTR_ROUND_ROBIN_EN to use rotating priority.
module interrupt_arbiter #(
    parameter int NUM_SRC    = 8,
    parameter int CAUSE_BASE = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [NUM_SRC-1:0] irq_enable,
    input  logic               global_ie,
    input  logic               trap_ack,
    input  logic               mret,
    output logic               trap_req,
    output logic [31:0]        trap_cause,
    output logic               in_isr,
    output logic [NUM_SRC-1:0] pending
);

    localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [NUM_SRC-1:0]  irq_prev;
    logic [NUM_SRC-1:0]  rise;
    logic [NUM_SRC-1:0]  eligible;
    logic [NUM_SRC-1:0]  clr_mask;
    logic [ID_W-1:0]     cur_id, id_nxt;
    logic [ID_W-1:0]     win_id;
    logic                win_vld;
    logic [30:0]         cause_code;
    logic                trap_req_nxt;
    logic                in_isr_nxt;
    logic [31:0]         cause_nxt;

    assign rise       = irq_in & ~irq_prev;
    assign eligible   = global_ie ? (pending & irq_enable) : '0;
    assign cause_code = 31'(CAUSE_BASE) + 31'(win_id);

`ifdef INTR_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr, rr_nxt;

    // Search begins at rr_ptr and wraps so the most recently served source goes last.
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_SRC;
            if (!win_vld && eligible[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        rr_nxt = rr_ptr;
        if (state == REQ && trap_ack) begin
            rr_nxt = (cur_id == ID_W'(NUM_SRC - 1)) ? '0 : cur_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_nxt;
        end
    end
`else
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_nxt    = state;
        id_nxt       = cur_id;
        trap_req_nxt = trap_req;
        in_isr_nxt   = in_isr;
        cause_nxt    = trap_cause;
        clr_mask     = '0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    id_nxt       = win_id;
                    cause_nxt    = {1'b1, cause_code};
                    trap_req_nxt = 1'b1;
                    state_nxt    = REQ;
                end
            end
            REQ: begin
                // The request is committed: nothing but ack (or reset) moves it, and mret is ignored here.
                if (trap_ack) begin
                    clr_mask     = NUM_SRC'(1) << cur_id;
                    trap_req_nxt = 1'b0;
                    in_isr_nxt   = 1'b1;
                    state_nxt    = SERVICE;
                end
            end
            SERVICE: begin
                if (mret) begin
                    in_isr_nxt = 1'b0;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cur_id     <= '0;
            trap_req   <= 1'b0;
            trap_cause <= '0;
            in_isr     <= 1'b0;
            irq_prev   <= '0;
            pending    <= '0;
        end else begin
            state      <= state_nxt;
            cur_id     <= id_nxt;
            trap_req   <= trap_req_nxt;
            trap_cause <= cause_nxt;
            in_isr     <= in_isr_nxt;
            irq_prev   <= irq_in;
            // A new edge on the acknowledged source survives its own clear.
            pending    <= (pending & ~clr_mask) | rise;
        end
    end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed-vector bench for interrupt_arbiter in its default fixed-priority build.
module tb_interrupt_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq_in;
    logic [7:0]  irq_enable;
    logic        global_ie;
    logic        trap_ack;
    logic        mret;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic        in_isr;
    logic [7:0]  pending;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    interrupt_arbiter #(.NUM_SRC(8), .CAUSE_BASE(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .irq_enable (irq_enable),
        .global_ie  (global_ie),
        .trap_ack   (trap_ack),
        .mret       (mret),
        .trap_req   (trap_req),
        .trap_cause (trap_cause),
        .in_isr     (in_isr),
        .pending    (pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs and samples both sit 1ns after it.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_irq(input logic [7:0] v);
        irq_in = v;
        step();
        irq_in = '0;
    endtask

    task automatic do_ack;
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
    endtask

    task automatic do_mret;
        mret = 1'b1;
        step();
        mret = 1'b0;
    endtask

    initial begin
        logic seen;
        reset = 1'b1; irq_in = '0; irq_enable = '0; global_ie = 1'b0;
        trap_ack = 1'b0; mret = 1'b0;
        step(2);
        reset = 1'b0;
        check("rst_req",     32'(trap_req),   32'h0);
        check("rst_cause",   trap_cause,      32'h0);
        check("rst_isr",     32'(in_isr),     32'h0);
        check("rst_pending", 32'(pending),    32'h0);

        // single event on src 3, with stray ack/mret while idle
        irq_enable = 8'hFF; global_ie = 1'b1;
        do_ack();
        check("idle_ack_ignored", 32'(in_isr), 32'h0);
        pulse_irq(8'h08);
        check("single_pend",   32'(pending),  32'h08);
        check("single_req_k",  32'(trap_req), 32'h0);
        step();
        check("single_req",    32'(trap_req), 32'h1);
        check("single_cause",  trap_cause,    32'h8000_0013);
        do_mret();
        check("req_mret_ignored_req", 32'(trap_req), 32'h1);
        check("req_mret_ignored_isr", 32'(in_isr),   32'h0);
        trap_ack = 1'b1; mret = 1'b1;
        step();
        trap_ack = 1'b0; mret = 1'b0;
        check("ack_mret_isr",  32'(in_isr),   32'h1);
        check("ack_pend_clr",  32'(pending),  32'h0);
        check("ack_req_drop",  32'(trap_req), 32'h0);
        do_mret();
        check("mret_isr",      32'(in_isr),   32'h0);

        // simultaneous sources 2 and 5
        pulse_irq(8'h24);
        step();
        check("simul_cause1",  trap_cause,    32'h8000_0012);
        do_ack();
        check("simul_pend",    32'(pending),  32'h20);
        do_mret();
        check("simul_gap",     32'(trap_req), 32'h0);
        step();
        check("simul_req2",    32'(trap_req), 32'h1);
        check("simul_cause2",  trap_cause,    32'h8000_0015);
        do_ack(); do_mret();

        // masking by irq_enable
        irq_enable = 8'h00;
        pulse_irq(8'h02);
        check("mask_pend",     32'(pending),  32'h02);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen |= trap_req;
        end
        check("mask_no_req",   32'(seen),     32'h0);
        irq_enable = 8'h02;
        step(2);
        check("unmask_req",    32'(trap_req), 32'h1);
        check("unmask_cause",  trap_cause,    32'h8000_0011);
        do_ack(); do_mret();

        // masking by global_ie
        irq_enable = 8'hFF; global_ie = 1'b0;
        pulse_irq(8'h02);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen |= trap_req;
        end
        check("gie_no_req",    32'(seen),     32'h0);
        check("gie_pend",      32'(pending),  32'h02);
        global_ie = 1'b1;
        step(2);
        check("gie_req",       32'(trap_req), 32'h1);
        do_ack(); do_mret();

        // request stability and no nesting
        pulse_irq(8'h10);
        step();
        check("stab_cause0",   trap_cause,    32'h8000_0014);
        global_ie = 1'b0;
        pulse_irq(8'h01);
        step(2);
        check("stab_req",      32'(trap_req), 32'h1);
        check("stab_cause",    trap_cause,    32'h8000_0014);
        check("stab_pend",     32'(pending),  32'h11);
        global_ie = 1'b1;
        do_ack();
        check("nest_pend",     32'(pending),  32'h01);
        step(3);
        check("nest_no_req",   32'(trap_req), 32'h0);
        check("nest_isr",      32'(in_isr),   32'h1);
        do_mret();
        step();
        check("after_ret_req",   32'(trap_req), 32'h1);
        check("after_ret_cause", trap_cause,    32'h8000_0010);
        do_ack(); do_mret();

        // set wins over ack clear on src 6
        pulse_irq(8'h40);
        step();
        check("setwin_cause0", trap_cause,    32'h8000_0016);
        irq_in = 8'h40; trap_ack = 1'b1;
        step();
        irq_in = '0; trap_ack = 1'b0;
        check("setwin_pend",   32'(pending),  32'h40);
        check("setwin_isr",    32'(in_isr),   32'h1);
        do_mret();
        step();
        check("setwin_req2",   32'(trap_req), 32'h1);
        check("setwin_cause2", trap_cause,    32'h8000_0016);
        do_ack(); do_mret();

        // held-high line generates one event only
        irq_in = 8'h08;
        step(2);
        check("level_req",     32'(trap_req), 32'h1);
        do_ack(); do_mret();
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen |= trap_req;
        end
        check("level_once",    32'(seen),     32'h0);
        irq_in = '0;
        step();

        // reset mid-REQ with another source pending
        irq_enable = 8'h04;
        pulse_irq(8'h84);
        step();
        check("rstreq_req",    32'(trap_req), 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstreq_req0",   32'(trap_req), 32'h0);
        check("rstreq_pend",   32'(pending),  32'h0);
        check("rstreq_isr",    32'(in_isr),   32'h0);
        check("rstreq_cause",  trap_cause,    32'h0);
        irq_enable = 8'hFF;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen |= trap_req;
        end
        check("rstreq_quiet",  32'(seen),     32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
